// File: rtl/memory_core.sv
// Single-port synchronous RAM: en=1 writes, en=0 reads with one-cycle latency.
// The read path and valid flag are registered, and reset clears every word.
module memory_core #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [ADDR_WIDTH-1:0] address,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out
);

   localparam int Depth = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [Depth];
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d;

   // Data holds across writes; only a read refreshes it.
   always_comb begin
      data_d  = data_q;
      valid_d = 1'b0;
      if (!en) begin
         data_d  = mem_q[address];
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   // Storage is flop-based so that reset can clear all locations in one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
         end
      end else if (en) begin
         mem_q[address] <= data_in;
      end
   end

   assign data_out  = data_q;
   assign valid_out = valid_q;

endmodule

// File: tb/tb_memory_core.sv
// Directed bench for memory_core: reset, write/read, full sweep, overwrite,
// reset during a write, and data hold across writes.
module tb_memory_core;

   logic        clk;
   logic        rst;
   logic        en;
   logic [31:0] data_in;
   logic [3:0]  address;
   logic [31:0] data_out;
   logic        valid_out;

   int checks = 0;
   int errors = 0;

   memory_core #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .data_in  (data_in),
      .address  (address),
      .data_out (data_out),
      .valid_out(valid_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply inputs away from the edge, clock once, sample 1 time unit later.
   task automatic step(input logic r, input logic e, input logic [3:0] a,
                       input logic [31:0] d);
      @(negedge clk);
      rst     = r;
      en      = e;
      address = a;
      data_in = d;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst     = 1'b1;
      en      = 1'b0;
      address = '0;
      data_in = '0;

      // Reset held two cycles
      step(1'b1, 1'b0, 4'd0, 32'h0);
      step(1'b1, 1'b0, 4'd0, 32'h0);
      check("rst_data", data_out, 32'h0);
      check("rst_valid", {31'b0, valid_out}, 32'd0);

      // First read after reset of a never-written address
      step(1'b0, 1'b0, 4'd5, 32'h0);
      check("rd5_data", data_out, 32'h0);
      check("rd5_valid", {31'b0, valid_out}, 32'd1);

      // Write then read
      step(1'b0, 1'b1, 4'd3, 32'hDEADBEEF);
      check("wr3_valid", {31'b0, valid_out}, 32'd0);
      check("wr3_hold", data_out, 32'h0);
      step(1'b0, 1'b0, 4'd3, 32'h0);
      check("rd3_data", data_out, 32'hDEADBEEF);
      check("rd3_valid", {31'b0, valid_out}, 32'd1);

      // Full sweep
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, 4'(i), 32'(i) * 32'h11111111);
         check("sweep_wr_valid", {31'b0, valid_out}, 32'd0);
      end
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b0, 4'(i), 32'h0);
         check("sweep_rd_data", data_out, 32'(i) * 32'h11111111);
         check("sweep_rd_valid", {31'b0, valid_out}, 32'd1);
      end

      // Overwrite at the top address
      step(1'b0, 1'b1, 4'd15, 32'hAAAAAAAA);
      step(1'b0, 1'b1, 4'd15, 32'h55555555);
      step(1'b0, 1'b0, 4'd15, 32'h0);
      check("ovr15_data", data_out, 32'h55555555);
      check("ovr15_valid", {31'b0, valid_out}, 32'd1);

      // Reset dominates a simultaneous write
      step(1'b0, 1'b1, 4'd7, 32'h12345678);
      step(1'b1, 1'b1, 4'd7, 32'hFFFFFFFF);
      check("rstwr_data", data_out, 32'h0);
      check("rstwr_valid", {31'b0, valid_out}, 32'd0);
      step(1'b0, 1'b0, 4'd7, 32'h0);
      check("rd7_data", data_out, 32'h0);
      check("rd7_valid", {31'b0, valid_out}, 32'd1);
      step(1'b0, 1'b0, 4'd3, 32'h0);
      check("rd3_cleared", data_out, 32'h0);

      // Hold behaviour across a write
      step(1'b0, 1'b1, 4'd2, 32'h0BADF00D);
      step(1'b0, 1'b0, 4'd2, 32'h0);
      check("rd2_data", data_out, 32'h0BADF00D);
      check("rd2_valid", {31'b0, valid_out}, 32'd1);
      step(1'b0, 1'b1, 4'd9, 32'h00000001);
      check("hold_data", data_out, 32'h0BADF00D);
      check("hold_valid", {31'b0, valid_out}, 32'd0);
      step(1'b0, 1'b0, 4'd9, 32'h0);
      check("rd9_data", data_out, 32'h00000001);
      step(1'b0, 1'b0, 4'd2, 32'h0);
      check("rd2_again", data_out, 32'h0BADF00D);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
